// File: rtl/layer_compositor.sv
// Priority layer compositor: the lowest-index drawing layer wins, with a 1-cycle registered output.
// Optional ball-vs-layer collision tracking is enabled by defining LAYER_COMPOSITOR_COLLISION_EN.
module layer_compositor #(
    parameter int unsigned        NUM_LAYERS  = 4,
    parameter int unsigned        COLOR_W     = 8,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0,
    parameter logic [COLOR_W-1:0] BACKGROUND  = '1,
    localparam int unsigned       IDX_W       = $clog2(NUM_LAYERS),
    localparam int unsigned       HIT_W       = NUM_LAYERS - 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          pixel_valid,
    input  logic                          start_of_frame,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    output logic [COLOR_W-1:0]            rgb_out,
    output logic                          rgb_valid,
    output logic [IDX_W-1:0]              winner_idx,
    output logic [HIT_W-1:0]              hit_pulse,
    output logic [HIT_W-1:0]              frame_hits,
    output logic [7:0]                    frame_hit_cnt,
    output logic                          frame_done
);

    localparam int unsigned CNT_W   = 8;
    localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

    logic [NUM_LAYERS-1:0] draw_c;

    logic [COLOR_W-1:0] rgb_d,   rgb_q;
    logic               valid_d, valid_q;
    logic [IDX_W-1:0]   idx_d,   idx_q;

    // A layer draws only on a visible pixel, when enabled and not transparent.
    always_comb begin
        draw_c = '0;
        for (int i = 0; i < int'(NUM_LAYERS); i++) begin
            draw_c[i] = pixel_valid && layer_en[i] &&
                        (layer_rgb[i*int'(COLOR_W) +: COLOR_W] != TRANSPARENT);
        end
    end

    // Scan from the top layer down so the lowest-index drawing layer is the last assignment.
    always_comb begin
        rgb_d   = BACKGROUND;
        idx_d   = '0;
        valid_d = pixel_valid;
        for (int i = int'(NUM_LAYERS) - 1; i >= 0; i--) begin
            if (draw_c[i]) begin
                rgb_d = layer_rgb[i*int'(COLOR_W) +: COLOR_W];
                idx_d = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rgb_q   <= BACKGROUND;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            rgb_q   <= rgb_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    assign rgb_out    = rgb_q;
    assign rgb_valid  = valid_q;
    assign winner_idx = idx_q;

`ifdef LAYER_COMPOSITOR_COLLISION_EN

    logic [HIT_W-1:0] hits_c;
    logic             any_hit_c;

    logic [HIT_W-1:0] hit_q;
    logic [HIT_W-1:0] acc_mask_d,    acc_mask_q;
    logic [CNT_W-1:0] acc_cnt_d,     acc_cnt_q;
    logic [HIT_W-1:0] frame_hits_d,  frame_hits_q;
    logic [CNT_W-1:0] frame_cnt_d,   frame_cnt_q;
    logic             done_d,        done_q;

    // Bit k-1 flags the ball layer overlapping layer k on this pixel.
    always_comb begin
        hits_c = '0;
        for (int k = 1; k < int'(NUM_LAYERS); k++) begin
            hits_c[k-1] = draw_c[0] && draw_c[k];
        end
        any_hit_c = |hits_c;
    end

    // Frame start snapshots the running totals; the current pixel seeds the new frame.
    always_comb begin
        acc_mask_d   = acc_mask_q | hits_c;
        acc_cnt_d    = acc_cnt_q;
        frame_hits_d = frame_hits_q;
        frame_cnt_d  = frame_cnt_q;
        done_d       = 1'b0;
        if (any_hit_c && (acc_cnt_q != CNT_MAX)) begin
            acc_cnt_d = acc_cnt_q + CNT_W'(1);
        end
        if (start_of_frame) begin
            frame_hits_d = acc_mask_q;
            frame_cnt_d  = acc_cnt_q;
            done_d       = 1'b1;
            acc_mask_d   = hits_c;
            acc_cnt_d    = CNT_W'(any_hit_c);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hit_q        <= '0;
            acc_mask_q   <= '0;
            acc_cnt_q    <= '0;
            frame_hits_q <= '0;
            frame_cnt_q  <= '0;
            done_q       <= 1'b0;
        end else begin
            hit_q        <= hits_c;
            acc_mask_q   <= acc_mask_d;
            acc_cnt_q    <= acc_cnt_d;
            frame_hits_q <= frame_hits_d;
            frame_cnt_q  <= frame_cnt_d;
            done_q       <= done_d;
        end
    end

    assign hit_pulse     = hit_q;
    assign frame_hits    = frame_hits_q;
    assign frame_hit_cnt = frame_cnt_q;
    assign frame_done    = done_q;

`else

    assign hit_pulse     = '0;
    assign frame_hits    = '0;
    assign frame_hit_cnt = '0;
    assign frame_done    = 1'b0;

`endif

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus randomized pixels
// compared against a frame-level reference model of compositing and collision counting.
module tb_layer_compositor;

    localparam int N  = 4;
    localparam int CW = 8;
    localparam int IW = $clog2(N);
    localparam int HW = N - 1;
`ifdef LAYER_COMPOSITOR_COLLISION_EN
    localparam bit COLL_EN = 1'b1;
`else
    localparam bit COLL_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset = 1'b1;
    logic            pixel_valid = 1'b0;
    logic            start_of_frame = 1'b0;
    logic [N*CW-1:0] layer_rgb = '0;
    logic [N-1:0]    layer_en = '0;
    logic [CW-1:0]   rgb_out;
    logic            rgb_valid;
    logic [IW-1:0]   winner_idx;
    logic [HW-1:0]   hit_pulse;
    logic [HW-1:0]   frame_hits;
    logic [7:0]      frame_hit_cnt;
    logic            frame_done;

    layer_compositor dut (
        .clk            (clk),
        .reset          (reset),
        .pixel_valid    (pixel_valid),
        .start_of_frame (start_of_frame),
        .layer_rgb      (layer_rgb),
        .layer_en       (layer_en),
        .rgb_out        (rgb_out),
        .rgb_valid      (rgb_valid),
        .winner_idx     (winner_idx),
        .hit_pulse      (hit_pulse),
        .frame_hits     (frame_hits),
        .frame_hit_cnt  (frame_hit_cnt),
        .frame_done     (frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: expected outputs and the running frame totals.
    int e_rgb, e_valid, e_idx, e_hit, e_fh, e_cnt, e_done;
    int m_mask, m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    endtask

    task automatic model_step(input bit rst, input bit pv, input bit sof,
                              input logic [N*CW-1:0] rgb, input logic [N-1:0] en);
        int winner;
        int hits;
        bit draws [N];
        for (int i = 0; i < N; i++) begin
            logic [CW-1:0] c;
            c = rgb[i*CW +: CW];
            draws[i] = pv && en[i] && (c != 8'h00);
        end
        winner = -1;
        for (int i = 0; i < N; i++) if (draws[i] && winner < 0) winner = i;
        hits = 0;
        for (int k = 1; k < N; k++) if (draws[0] && draws[k]) hits += (1 << (k - 1));

        if (rst) begin
            e_rgb = 'hFF; e_valid = 0; e_idx = 0; e_hit = 0;
            e_fh = 0; e_cnt = 0; e_done = 0; m_mask = 0; m_cnt = 0;
        end else begin
            e_valid = pv ? 1 : 0;
            e_rgb   = (winner >= 0) ? int'(rgb[winner*CW +: CW]) : 'hFF;
            e_idx   = (winner >= 0) ? winner : 0;
            e_hit   = hits;
            if (sof) begin
                e_fh = m_mask; e_cnt = m_cnt; e_done = 1;
                m_mask = hits; m_cnt = (hits != 0) ? 1 : 0;
            end else begin
                e_done = 0;
                m_mask = m_mask | hits;
                if (hits != 0 && m_cnt < 255) m_cnt++;
            end
        end
    endtask

    task automatic compare_all();
        check("rgb_out",       32'(rgb_out),       32'(e_rgb));
        check("rgb_valid",     32'(rgb_valid),     32'(e_valid));
        check("winner_idx",    32'(winner_idx),    32'(e_idx));
        check("hit_pulse",     32'(hit_pulse),     COLL_EN ? 32'(e_hit)  : 32'd0);
        check("frame_hits",    32'(frame_hits),    COLL_EN ? 32'(e_fh)   : 32'd0);
        check("frame_hit_cnt", 32'(frame_hit_cnt), COLL_EN ? 32'(e_cnt)  : 32'd0);
        check("frame_done",    32'(frame_done),    COLL_EN ? 32'(e_done) : 32'd0);
    endtask

    task automatic cycle(input bit rst, input bit pv, input bit sof,
                         input logic [N*CW-1:0] rgb, input logic [N-1:0] en);
        @(negedge clk);
        reset = rst; pixel_valid = pv; start_of_frame = sof;
        layer_rgb = rgb; layer_en = en;
        model_step(rst, pv, sof, rgb, en);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    localparam logic [N*CW-1:0] PIX_A   = {8'h00, 8'h1C, 8'h00, 8'hE0};
    localparam logic [N*CW-1:0] PIX_01  = {8'h00, 8'h00, 8'hAA, 8'h11};
    localparam logic [N*CW-1:0] PIX_03  = {8'h33, 8'h00, 8'h00, 8'h11};
    localparam logic [N*CW-1:0] PIX_0   = {8'h00, 8'h00, 8'h00, 8'h00};

    initial begin
        // Reset state
        cycle(1, 0, 0, PIX_0, '1);
        cycle(1, 1, 1, PIX_A, '1);
        check("reset_rgb", 32'(rgb_out), 32'hFF);
        check("reset_cnt", 32'(frame_hit_cnt), 32'd0);

        // Basic priority with a layer0/layer2 overlap
        cycle(0, 1, 0, PIX_A, 4'b1111);
        check("prio_rgb", 32'(rgb_out), 32'hE0);
        check("prio_idx", 32'(winner_idx), 32'd0);
        check("prio_hit", 32'(hit_pulse), COLL_EN ? 32'b010 : 32'd0);

        // Ball disabled: layer 2 shows, no collision
        cycle(0, 1, 0, PIX_A, 4'b1110);
        check("dis_rgb", 32'(rgb_out), 32'h1C);
        check("dis_idx", 32'(winner_idx), 32'd2);

        // All transparent, then blanking
        cycle(0, 1, 0, PIX_0, 4'b1111);
        check("bg_valid", 32'(rgb_valid), 32'd1);
        cycle(0, 0, 0, PIX_A, 4'b1111);
        check("blank_rgb", 32'(rgb_out), 32'hFF);

        // Counter saturation over 300 collision pixels hitting layers 1 and 3
        cycle(0, 0, 1, PIX_0, '1);
        for (int i = 0; i < 300; i++) cycle(0, 1, 0, (i % 2) ? PIX_01 : PIX_03, '1);
        cycle(0, 0, 1, PIX_0, '1);
        check("sat_cnt", 32'(frame_hit_cnt), COLL_EN ? 32'd255 : 32'd0);
        check("sat_mask", 32'(frame_hits), COLL_EN ? 32'b101 : 32'd0);

        // Collision coincident with frame start belongs to the new frame
        cycle(0, 1, 0, PIX_03, '1);
        cycle(0, 1, 1, PIX_01, '1);
        check("sof_excl_cnt", 32'(frame_hit_cnt), COLL_EN ? 32'd1 : 32'd0);
        check("sof_excl_mask", 32'(frame_hits), COLL_EN ? 32'b100 : 32'd0);
        cycle(0, 0, 1, PIX_0, '1);
        check("sof_next_cnt", 32'(frame_hit_cnt), COLL_EN ? 32'd1 : 32'd0);
        check("sof_next_mask", 32'(frame_hits), COLL_EN ? 32'b001 : 32'd0);

        // Back-to-back frame starts
        cycle(0, 1, 1, PIX_03, '1);
        cycle(0, 0, 1, PIX_0, '1);
        check("b2b_done", 32'(frame_done), COLL_EN ? 32'd1 : 32'd0);
        check("b2b_mask", 32'(frame_hits), COLL_EN ? 32'b100 : 32'd0);

        // Mid-frame reset discards earlier hits
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, PIX_01, '1);
        cycle(1, 1, 1, PIX_01, '1);
        for (int i = 0; i < 2; i++) cycle(0, 1, 0, PIX_03, '1);
        cycle(0, 0, 1, PIX_0, '1);
        check("rst_cnt", 32'(frame_hit_cnt), COLL_EN ? 32'd2 : 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            logic [N*CW-1:0] r;
            logic [N-1:0] en;
            for (int i = 0; i < N; i++)
                r[i*CW +: CW] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            en = N'($urandom);
            if ($urandom_range(0, 3) != 0) en[0] = 1'b1;
            cycle(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) != 0),
                  ($urandom_range(0, 39) == 0), r, en);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
